// File: rtl/vga_mode_sequencer.sv
// VGA mode sequencer: command-programmed shadow timing/pattern set, committed
// atomically to the active set on frame boundaries, with optional pattern auto-cycle.
module vga_mode_sequencer #(
    parameter int PERIOD_W = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_addr,
    input  logic [11:0] cmd_data,
    input  logic        frame_end,
    output logic [11:0] hdisplay,
    output logic [11:0] vdisplay,
    output logic [9:0]  hfrontporch,
    output logic [9:0]  hsynclength,
    output logic [9:0]  hbackporch,
    output logic [7:0]  vfrontporch,
    output logic [7:0]  vsynclength,
    output logic [7:0]  vbackporch,
    output logic        hsyncpolarity,
    output logic        vsyncpolarity,
    output logic [4:0]  pattern,
    output logic [5:0]  color_in,
    output logic        pending,
    output logic        applied
);

    typedef struct packed {
        logic [11:0] hdisplay;
        logic [9:0]  hfrontporch;
        logic [9:0]  hsynclength;
        logic [9:0]  hbackporch;
        logic        hsyncpolarity;
        logic [11:0] vdisplay;
        logic [7:0]  vfrontporch;
        logic [7:0]  vsynclength;
        logic [7:0]  vbackporch;
        logic        vsyncpolarity;
        logic [5:0]  color_in;
        logic [4:0]  pattern;
    } mode_t;

    localparam mode_t PRESET = '{
        hdisplay:      12'd640,
        hfrontporch:   10'd16,
        hsynclength:   10'd96,
        hbackporch:    10'd48,
        hsyncpolarity: 1'b0,
        vdisplay:      12'd480,
        vfrontporch:   8'd10,
        vsynclength:   8'd2,
        vbackporch:    8'd33,
        vsyncpolarity: 1'b0,
        color_in:      6'd0,
        pattern:       5'd31
    };

    localparam logic [3:0] ADDR_COMMIT = 4'd10;
    localparam logic [3:0] ADDR_PRESET = 4'd11;
    localparam logic [3:0] ADDR_INC    = 4'd12;
    localparam logic [3:0] ADDR_DEC    = 4'd13;
    localparam logic [3:0] ADDR_PERIOD = 4'd14;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PENDING,
        ST_APPLY
    } state_t;

    state_t              state_reg, state_next;
    mode_t               shadow_reg;
    mode_t               active_reg;
    logic [PERIOD_W-1:0] period_reg;
    logic [PERIOD_W-1:0] frame_cnt_reg;
    logic [PERIOD_W-1:0] period_last;
    logic                applied_reg;
    logic                apply_now;
    logic                cmd_fire;

    assign cmd_fire    = cmd_valid & cmd_ready;
    assign period_last = period_reg - 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // frame_end is only looked at from PENDING, so a commit accepted on a
    // frame_end cycle naturally waits for the next frame boundary.
    always_comb begin
        state_next = state_reg;
        cmd_ready  = 1'b0;
        pending    = 1'b0;
        apply_now  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid && cmd_addr == ADDR_COMMIT) begin
                    state_next = ST_PENDING;
                end
            end
            ST_PENDING: begin
                pending = 1'b1;
                if (frame_end) begin
                    state_next = ST_APPLY;
                end
            end
            ST_APPLY: begin
                apply_now  = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_reg <= PRESET;
        end else if (cmd_fire) begin
            case (cmd_addr)
                4'd0: shadow_reg.hdisplay <= cmd_data;
                4'd1: shadow_reg.hfrontporch <= cmd_data[9:0];
                4'd2: begin
                    shadow_reg.hsynclength   <= cmd_data[9:0];
                    shadow_reg.hsyncpolarity <= cmd_data[10];
                end
                4'd3: shadow_reg.hbackporch <= cmd_data[9:0];
                4'd4: shadow_reg.vdisplay <= cmd_data;
                4'd5: shadow_reg.vfrontporch <= cmd_data[7:0];
                4'd6: begin
                    shadow_reg.vsynclength   <= cmd_data[7:0];
                    shadow_reg.vsyncpolarity <= cmd_data[8];
                end
                4'd7: shadow_reg.vbackporch <= cmd_data[7:0];
                4'd8: shadow_reg.color_in <= cmd_data[5:0];
                4'd9: shadow_reg.pattern <= cmd_data[4:0];
                ADDR_PRESET: shadow_reg <= PRESET;
                ADDR_INC: shadow_reg.pattern <= shadow_reg.pattern + 5'd1;
                ADDR_DEC: shadow_reg.pattern <= shadow_reg.pattern - 5'd1;
                default: ;
            endcase
        end
    end

    // Apply takes priority over an auto-cycle step so the committed pattern wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active_reg    <= PRESET;
            period_reg    <= '0;
            frame_cnt_reg <= '0;
            applied_reg   <= 1'b0;
        end else begin
            applied_reg <= apply_now;
            if (apply_now) begin
                active_reg    <= shadow_reg;
                frame_cnt_reg <= '0;
            end else if (frame_end && period_reg != '0) begin
                if (frame_cnt_reg == period_last) begin
                    frame_cnt_reg      <= '0;
                    active_reg.pattern <= active_reg.pattern + 5'd1;
                end else begin
                    frame_cnt_reg <= frame_cnt_reg + 1'b1;
                end
            end
            if (cmd_fire && cmd_addr == ADDR_PERIOD) begin
                period_reg    <= cmd_data[PERIOD_W-1:0];
                frame_cnt_reg <= '0;
            end
        end
    end

    assign hdisplay      = active_reg.hdisplay;
    assign hfrontporch   = active_reg.hfrontporch;
    assign hsynclength   = active_reg.hsynclength;
    assign hbackporch    = active_reg.hbackporch;
    assign hsyncpolarity = active_reg.hsyncpolarity;
    assign vdisplay      = active_reg.vdisplay;
    assign vfrontporch   = active_reg.vfrontporch;
    assign vsynclength   = active_reg.vsynclength;
    assign vbackporch    = active_reg.vbackporch;
    assign vsyncpolarity = active_reg.vsyncpolarity;
    assign color_in      = active_reg.color_in;
    assign pattern       = active_reg.pattern;
    assign applied       = applied_reg;

endmodule

// File: tb/tb_vga_mode_sequencer.sv
// Bench for vga_mode_sequencer: directed scenarios plus random command/frame
// traffic checked against a field-array reference model.
module tb_vga_mode_sequencer;

    localparam int PW = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_addr;
    logic [11:0] cmd_data;
    logic        frame_end;
    logic [11:0] hdisplay, vdisplay;
    logic [9:0]  hfrontporch, hsynclength, hbackporch;
    logic [7:0]  vfrontporch, vsynclength, vbackporch;
    logic        hsyncpolarity, vsyncpolarity;
    logic [4:0]  pattern;
    logic [5:0]  color_in;
    logic        pending, applied;

    vga_mode_sequencer #(.PERIOD_W(PW)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data), .frame_end(frame_end),
        .hdisplay(hdisplay), .vdisplay(vdisplay),
        .hfrontporch(hfrontporch), .hsynclength(hsynclength), .hbackporch(hbackporch),
        .vfrontporch(vfrontporch), .vsynclength(vsynclength), .vbackporch(vbackporch),
        .hsyncpolarity(hsyncpolarity), .vsyncpolarity(vsyncpolarity),
        .pattern(pattern), .color_in(color_in),
        .pending(pending), .applied(applied)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Field order: hdisp hfp hsl hbp vdisp vfp vsl vbp color pattern hpol vpol
    int wid[12]    = '{12, 10, 10, 10, 12, 8, 8, 8, 6, 5, 1, 1};
    int preset[12] = '{640, 16, 96, 48, 480, 10, 2, 33, 0, 31, 0, 0};
    int sh[12];
    int ac[12];
    int period;
    int frames;
    bit waiting;
    bit busy;
    bit exp_applied;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic compare_all(input string ctx);
        check_val({ctx, ":hdisplay"},    32'(hdisplay),      32'(ac[0]));
        check_val({ctx, ":hfrontporch"}, 32'(hfrontporch),   32'(ac[1]));
        check_val({ctx, ":hsynclength"}, 32'(hsynclength),   32'(ac[2]));
        check_val({ctx, ":hbackporch"},  32'(hbackporch),    32'(ac[3]));
        check_val({ctx, ":vdisplay"},    32'(vdisplay),      32'(ac[4]));
        check_val({ctx, ":vfrontporch"}, 32'(vfrontporch),   32'(ac[5]));
        check_val({ctx, ":vsynclength"}, 32'(vsynclength),   32'(ac[6]));
        check_val({ctx, ":vbackporch"},  32'(vbackporch),    32'(ac[7]));
        check_val({ctx, ":color_in"},    32'(color_in),      32'(ac[8]));
        check_val({ctx, ":pattern"},     32'(pattern),       32'(ac[9]));
        check_val({ctx, ":hsyncpol"},    32'(hsyncpolarity), 32'(ac[10]));
        check_val({ctx, ":vsyncpol"},    32'(vsyncpolarity), 32'(ac[11]));
        check_val({ctx, ":pending"},     32'(pending),       32'(waiting));
        check_val({ctx, ":cmd_ready"},   32'(cmd_ready),     32'(!(waiting || busy)));
        check_val({ctx, ":applied"},     32'(applied),       32'(exp_applied));
        $display("%s: hd=%0d vd=%0d pat=%0d col=%0d pend=%0d rdy=%0d app=%0d",
                 ctx, hdisplay, vdisplay, pattern, color_in, pending, cmd_ready, applied);
    endtask

    task automatic model_reset();
        sh = preset;
        ac = preset;
        period = 0;
        frames = 0;
        waiting = 0;
        busy = 0;
        exp_applied = 0;
    endtask

    task automatic model_cmd(input int a, input int d);
        if (a <= 9) begin
            sh[a] = d % (1 << wid[a]);
            if (a == 2) sh[10] = (d >> 10) & 1;
            if (a == 6) sh[11] = (d >> 8) & 1;
        end else if (a == 10) waiting = 1;
        else if (a == 11) sh = preset;
        else if (a == 12) sh[9] = (sh[9] + 1) % 32;
        else if (a == 13) sh[9] = (sh[9] + 31) % 32;
        else if (a == 14) begin
            period = d % (1 << PW);
            frames = 0;
        end
    endtask

    // Auto-cycle: one pattern step every 'period' frames.
    task automatic model_frame();
        if (period != 0) begin
            frames++;
            if (frames == period) begin
                frames = 0;
                ac[9] = (ac[9] + 1) % 32;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input int a, input int d);
        int t = 0;
        while (!cmd_ready && t < 200) begin
            tick();
            t++;
        end
        if (!cmd_ready) check_val("ready_timeout", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_addr  = 4'(a);
        cmd_data  = 12'(d);
        tick();
        cmd_valid = 1'b0;
        model_cmd(a, d);
        compare_all($sformatf("cmd a=%0d d=%0d", a, d));
    endtask

    task automatic frame_pulse();
        bit was_waiting = waiting;
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        model_frame();
        if (was_waiting) begin
            waiting = 0;
            busy = 1;
        end
        compare_all("frame");
        if (was_waiting) begin
            tick();
            ac = sh;
            frames = 0;
            busy = 0;
            exp_applied = 1;
            compare_all("apply");
            tick();
            exp_applied = 0;
            compare_all("post_apply");
        end
    endtask

    task automatic commit_with_frame();
        cmd_valid = 1'b1;
        cmd_addr  = 4'd10;
        cmd_data  = 12'd0;
        frame_end = 1'b1;
        tick();
        cmd_valid = 1'b0;
        frame_end = 1'b0;
        model_frame();
        waiting = 1;
        compare_all("commit+frame");
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
        compare_all($sformatf("idle %0d", n));
    endtask

    task automatic async_reset();
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        model_reset();
        compare_all("async_reset");
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        compare_all("reset_release");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        cmd_valid = 1'b0;
        cmd_addr = 4'd0;
        cmd_data = 12'd0;
        frame_end = 1'b0;
        model_reset();
        repeat (2) tick();
        compare_all("reset");
        reset = 1'b0;
        tick();
        compare_all("after_reset");

        // Commit waits for a frame boundary
        send_cmd(0, 800);
        send_cmd(4, 600);
        send_cmd(10, 0);
        idle(100);
        frame_pulse();

        // Commit coincident with frame_end is deferred to the next one
        send_cmd(0, 1024);
        send_cmd(2, 12'h400 | 100);
        send_cmd(6, 12'h100 | 5);
        commit_with_frame();
        idle(5);
        frame_pulse();

        // Pattern wrap in both directions
        send_cmd(9, 0);
        send_cmd(13, 0);
        send_cmd(10, 0);
        frame_pulse();
        send_cmd(12, 0);
        send_cmd(10, 0);
        frame_pulse();

        // Commands offered while pending are not accepted
        send_cmd(8, 45);
        send_cmd(10, 0);
        cmd_valid = 1'b1;
        cmd_addr = 4'd0;
        cmd_data = 12'd7;
        repeat (3) tick();
        cmd_valid = 1'b0;
        compare_all("held_while_pending");
        frame_pulse();

        // Auto-cycle
        async_reset();
        send_cmd(14, 3);
        repeat (6) begin
            frame_pulse();
            idle(2);
        end
        send_cmd(14, 0);
        repeat (4) frame_pulse();

        // Reset discards a pending commit
        send_cmd(0, 1024);
        send_cmd(10, 0);
        idle(3);
        async_reset();
        frame_pulse();
        idle(3);

        for (int i = 0; i < 80; i++) begin
            int r = $urandom_range(0, 9);
            if (r <= 4) begin
                int a = $urandom_range(0, 13);
                if (a == 10) a = 15;
                send_cmd(a, int'($urandom_range(0, 4095)));
            end else if (r == 5) begin
                send_cmd(14, int'($urandom_range(0, 4)));
            end else if (r <= 7) begin
                frame_pulse();
            end else if (r == 8) begin
                send_cmd(10, 0);
                idle(int'($urandom_range(0, 5)));
                frame_pulse();
            end else begin
                commit_with_frame();
                idle(int'($urandom_range(0, 5)));
                frame_pulse();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
